ce_synth: RTL and testbench

Multi-channel fractional clock-enable synthesiser that sits directly behind the core PLL. It runs on one PLL output and derives NUM_CH independent clock-enable strobes from it, each at a runtime-programmable rational ratio num/den of the input clock. All channels restart phase-aligned whenever any ratio changes. A PLL-style `locked` flag tells downstream logic when the strobes are stable.

---
 rtl/ce_synth.sv | 102 ++++++++++
 tb/tb_ce_synth.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ce_synth.sv
// ce_synth: multi-channel fractional clock-enable synthesiser with PLL-style lock flag
// Ports:
//   refclk    in   clock, all logic on rising edge
//   rst       in   synchronous active-high reset
//   hold      in   freeze accumulators and force ce low
//   cfg_valid in   ratio write request
//   cfg_ready out  ratio write can be accepted (low in APPLY and during rst)
//   cfg_ch    in   target channel
//   cfg_num   in   new numerator
//   cfg_den   in   new denominator
//   ce        out  registered one-cycle enable strobes, one per channel
//   locked    out  strobes stable and configuration settled
module ce_synth #(
    parameter int NUM_CH = 4,
    parameter int ACC_W = 16,
    parameter int LOCK_CYCLES = 64,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = '0,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = '0,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              hold,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);
    localparam int CNT_W = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
    typedef enum logic [1:0] {SETTLE, RUN, APPLY} state_t;
    state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CH_W-1:0] r_sh_ch;
    logic [ACC_W-1:0] r_sh_num, r_sh_den;
    logic w_accept;
    assign cfg_ready = !rst && r_state != APPLY;
    // writes to nonexistent channels are handshaken but have no effect
    assign w_accept = cfg_valid && cfg_ready && int'(cfg_ch) < NUM_CH;
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == APPLY)
            w_state_nxt = SETTLE;
        else if (w_accept)
            w_state_nxt = APPLY;
        else if (r_state == SETTLE && r_cnt == CNT_W'(LOCK_CYCLES - 1))
            w_state_nxt = RUN;
    end
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state  <= SETTLE;
            r_cnt    <= '0;
            locked   <= 1'b0;
            r_sh_ch  <= '0;
            r_sh_num <= '0;
            r_sh_den <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == SETTLE && w_state_nxt == SETTLE) ? r_cnt + CNT_W'(1) : '0;
            // lags the RUN transition by one edge; an accept drops it immediately
            locked  <= r_state == RUN && !w_accept;
            if (w_accept) begin
                r_sh_ch  <= cfg_ch;
                r_sh_num <= cfg_num;
                r_sh_den <= cfg_den;
            end
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] r_num, r_den, r_acc, w_neff;
        logic [ACC_W:0] w_sum;
        logic r_ce, w_hit;
        assign w_neff = r_num < r_den ? r_num : r_den;
        assign w_sum  = {1'b0, r_acc} + {1'b0, w_neff};
        assign w_hit  = w_sum >= {1'b0, r_den};
        assign ce[g]  = r_ce;
        always_ff @(posedge refclk) begin
            if (rst) begin
                r_num <= DEF_NUM[g*ACC_W +: ACC_W];
                r_den <= DEF_DEN[g*ACC_W +: ACC_W];
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (r_state == APPLY) begin
                // common phase origin for every channel
                r_acc <= '0;
                r_ce  <= 1'b0;
                if (r_sh_ch == CH_W'(g)) begin
                    r_num <= r_sh_num;
                    r_den <= r_sh_den;
                end
            end else if (hold || r_den == '0) begin
                // a disabled channel's acc is already 0 since den only changes in APPLY
                r_ce <= 1'b0;
            end else begin
                r_acc <= w_hit ? ACC_W'(w_sum - {1'b0, r_den}) : w_sum[ACC_W-1:0];
                r_ce  <= w_hit;
            end
        end
    end
endmodule

// File: tb/tb_ce_synth.sv
// tb_ce_synth: directed self-checking bench for ce_synth
module tb_ce_synth;
    localparam int NUM_CH = 5;
    localparam int ACC_W = 16;
    localparam int LOCK = 4;
    localparam int CH_W = 3;
    logic refclk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic [CH_W-1:0] cfg_ch = '0;
    logic [ACC_W-1:0] cfg_num = '0;
    logic [ACC_W-1:0] cfg_den = '0;
    logic [NUM_CH-1:0] ce;
    logic locked;
    int checks = 0;
    int errors = 0;
    int cnt1, cnt2, cnt34;
    typedef struct {
        logic v;
        logic [CH_W-1:0] ch;
        logic [ACC_W-1:0] n;
        logic [ACC_W-1:0] d;
        logic [NUM_CH-1:0] ce;
        logic lk;
        logic rdy;
    } vec_t;
    vec_t tbl[28];
    always #5 refclk = ~refclk;
    ce_synth #(
        .NUM_CH(NUM_CH),
        .ACC_W(ACC_W),
        .LOCK_CYCLES(LOCK),
        .DEF_NUM(80'd1),
        .DEF_DEN(80'd6)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .hold(hold),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_num(cfg_num),
        .cfg_den(cfg_den),
        .ce(ce),
        .locked(locked)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge refclk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        hold = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) step();
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_ce", 32'(ce), 0);
        rst = 1'b0;
    endtask
    task automatic wr(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] n, input logic [ACC_W-1:0] d);
        cfg_valid = 1'b1;
        cfg_ch = ch;
        cfg_num = n;
        cfg_den = d;
    endtask
    initial begin
        for (int k = 1; k <= 28; k++)
            tbl[k-1] = '{v: 1'b0, ch: '0, n: '0, d: '0, ce: '0, lk: k >= 5, rdy: 1'b1};
        tbl[5].ce = 5'b00001;
        tbl[11].ce = 5'b00001;
        tbl[13] = '{v: 1'b1, ch: 3'd2, n: 16'd2, d: 16'd5, ce: '0, lk: 1'b0, rdy: 1'b0};
        for (int k = 15; k <= 19; k++) tbl[k-1].lk = 1'b0;
        tbl[17].ce = 5'b00100;
        tbl[19].ce = 5'b00100;
        tbl[22].ce = 5'b00100;
        tbl[24].ce = 5'b00100;
        tbl[27].ce = 5'b00100;
        tbl[20].ce = 5'b00001;
        tbl[26].ce = 5'b00001;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            cfg_valid = tbl[i].v;
            cfg_ch = tbl[i].ch;
            cfg_num = tbl[i].n;
            cfg_den = tbl[i].d;
            step();
            chk($sformatf("tbl%0d_ce", i + 1), 32'(ce), 32'(tbl[i].ce));
            chk($sformatf("tbl%0d_locked", i + 1), 32'(locked), 32'(tbl[i].lk));
            chk($sformatf("tbl%0d_ready", i + 1), 32'(cfg_ready), 32'(tbl[i].rdy));
        end
        cfg_valid = 1'b0;
        cnt1 = 0;
        cnt2 = 0;
        cnt34 = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            cnt1 += int'(ce[1]);
            cnt2 += int'(ce[2]);
            cnt34 += int'(ce[3]) + int'(ce[4]);
        end
        chk("count_ce2", cnt2, 400);
        chk("count_ce1", cnt1, 0);
        chk("count_ce34", cnt34, 0);
        // ch3 = 9/4 then 7/0
        do_reset();
        repeat (6) step();
        wr(3'd3, 16'd9, 16'd4);
        step();
        chk("w94_locked", 32'(locked), 0);
        chk("w94_ready", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        step();
        chk("w94_apply_ce", 32'(ce), 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("w94_ce3_%0d", k), 32'(ce[3]), 1);
            chk($sformatf("w94_locked_%0d", k), 32'(locked), 32'(k >= 5));
        end
        wr(3'd3, 16'd7, 16'd0);
        step();
        chk("w70_locked", 32'(locked), 0);
        cfg_valid = 1'b0;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("w70_ce3_%0d", k), 32'(ce[3]), 0);
            chk($sformatf("w70_acc3_%0d", k), 32'(dut.g_ch[3].r_acc), 0);
        end
        // out-of-range channel during RUN
        do_reset();
        repeat (7) step();
        wr(3'd5, 16'd3, 16'd3);
        chk("bad_ch_ready", 32'(cfg_ready), 1);
        step();
        chk("bad_ch_locked", 32'(locked), 1);
        chk("bad_ch_ready_after", 32'(cfg_ready), 1);
        cfg_valid = 1'b0;
        for (int e = 9; e <= 20; e++) begin
            step();
            chk($sformatf("bad_ch_ce_e%0d", e), 32'(ce), 32'(e % 6 == 0));
            chk($sformatf("bad_ch_locked_e%0d", e), 32'(locked), 1);
        end
        // write in SETTLE with valid held through APPLY, then a second SETTLE write
        do_reset();
        repeat (2) step();
        wr(3'd2, 16'd1, 16'd3);
        step();
        chk("settle_w1_ready", 32'(cfg_ready), 0);
        step();
        chk("no_double_accept", 32'(cfg_ready), 1);
        cfg_valid = 1'b0;
        step();
        wr(3'd3, 16'd1, 16'd2);
        step();
        chk("settle_w2_ready", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        step();
        chk("settle_w2_apply_ce", 32'(ce), 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("settle_ce_%0d", k), 32'(ce),
                32'({1'b0, k % 2 == 0, k % 3 == 0, 1'b0, k % 6 == 0}));
            chk($sformatf("settle_locked_%0d", k), 32'(locked), 32'(k >= 5));
        end
        // hold for 10 cycles mid-pattern
        do_reset();
        repeat (8) step();
        hold = 1'b1;
        for (int e = 9; e <= 18; e++) begin
            step();
            chk($sformatf("hold_ce_e%0d", e), 32'(ce), 0);
            chk($sformatf("hold_locked_e%0d", e), 32'(locked), 1);
        end
        hold = 1'b0;
        for (int e = 19; e <= 28; e++) begin
            step();
            chk($sformatf("resume_ce_e%0d", e), 32'(ce), 32'(e == 22 || e == 28));
        end
        // reset with a write pending in APPLY
        do_reset();
        repeat (2) step();
        wr(3'd0, 16'd1, 16'd2);
        step();
        chk("pend_ready", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("pend_rst_ready", 32'(cfg_ready), 0);
        chk("pend_rst_locked", 32'(locked), 0);
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("pend_ce_e%0d", e), 32'(ce), 32'(e % 6 == 0));
            chk($sformatf("pend_locked_e%0d", e), 32'(locked), 32'(e >= 5));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
